// File: rtl/mem_block_mover_pkg.sv
// -----------------------------------------------------------------------------
// mem_block_mover_pkg
// Shared constants for the block mover: main memory geometry (1024 x 16),
// the command mode encodings and the mover FSM state encoding.
// -----------------------------------------------------------------------------
package mem_block_mover_pkg;

  localparam int MEM_ADDR_W = 10;
  localparam int MEM_DATA_W = 16;
  localparam int MEM_LEN_W  = 11;
  localparam int MEM_DEPTH  = 1 << MEM_ADDR_W;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage : mem_block_mover_pkg

// File: rtl/mem_block_mover.sv
// -----------------------------------------------------------------------------
// mem_block_mover
// Bus initiator for the single-port main memory. Executes one block command
// at a time: COPY (read a source word, write it to the destination, repeat)
// or FILL (write a constant). Owns the memory port while busy is high.
//
// Ports:
//   clk, rst_n     clock (rising edge) and synchronous active-low reset
//   start          command strobe, only honoured while idle
//   mode           0 = COPY, 1 = FILL
//   src_addr       COPY source base address
//   dst_addr       destination base address
//   len            word count, values above the memory depth saturate
//   fill_data      FILL constant
//   busy           high from the cycle after an accepted start through DONE
//   done           one-cycle completion pulse
//   checksum       sum mod 2^DATA_W of every word written by the last command
//   mem_addr       memory address (registered)
//   mem_w_en       memory write enable (registered)
//   mem_wdata      memory write data (registered)
//   mem_rdata      combinational memory read data for mem_addr
// -----------------------------------------------------------------------------
module mem_block_mover
  import mem_block_mover_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int LEN_W  = MEM_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_w_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

  state_e            state_q;
  logic              mode_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx_q;
  logic [DATA_W-1:0] fill_q;
  logic              busy_q;
  logic              done_q;
  logic              w_en_q;
  logic [ADDR_W-1:0] addr_q;
  // Holds the word being written; in COPY it doubles as the read buffer.
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] csum_q;

  logic [LEN_W-1:0]  len_sat_d;
  logic [LEN_W-1:0]  idx_d;
  logic              last_d;
  logic [ADDR_W-1:0] dst_cur_d;
  logic [ADDR_W-1:0] src_nxt_d;
  logic [ADDR_W-1:0] dst_nxt_d;

  // Address sums are ADDR_W wide so they wrap around the memory naturally.
  assign len_sat_d = (len > MAX_LEN) ? MAX_LEN : len;
  assign idx_d     = idx_q + LEN_W'(1);
  assign last_d    = (idx_d == len_q);
  assign dst_cur_d = dst_q + idx_q[ADDR_W-1:0];
  assign src_nxt_d = src_q + idx_d[ADDR_W-1:0];
  assign dst_nxt_d = dst_q + idx_d[ADDR_W-1:0];

  // Memory pins are set up one edge ahead so every pin is a flop output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_COPY;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      fill_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      w_en_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      csum_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          w_en_q <= 1'b0;
          if (start) begin
            mode_q <= mode;
            src_q  <= src_addr;
            dst_q  <= dst_addr;
            len_q  <= len_sat_d;
            fill_q <= fill_data;
            idx_q  <= '0;
            csum_q <= '0;
            busy_q <= 1'b1;
            if (len_sat_d == '0) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else if (mode == MODE_COPY) begin
              addr_q  <= src_addr;
              state_q <= ST_RD;
            end else begin
              addr_q  <= dst_addr;
              w_en_q  <= 1'b1;
              wdata_q <= fill_data;
              state_q <= ST_WR;
            end
          end
        end

        ST_RD: begin
          wdata_q <= mem_rdata;
          addr_q  <= dst_cur_d;
          w_en_q  <= 1'b1;
          state_q <= ST_WR;
        end

        ST_WR: begin
          csum_q <= csum_q + wdata_q;
          idx_q  <= idx_d;
          if (last_d) begin
            w_en_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if (mode_q == MODE_COPY) begin
            w_en_q  <= 1'b0;
            addr_q  <= src_nxt_d;
            state_q <= ST_RD;
          end else begin
            addr_q  <= dst_nxt_d;
            wdata_q <= fill_q;
            state_q <= ST_WR;
          end
        end

        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          w_en_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign checksum  = csum_q;
  assign mem_addr  = addr_q;
  assign mem_w_en  = w_en_q;
  assign mem_wdata = wdata_q;

endmodule : mem_block_mover

// File: tb/tb_mem_block_mover.sv
// -----------------------------------------------------------------------------
// tb_mem_block_mover
// Bench for the block mover: a behavioural 1024x16 memory on the mover's bus,
// a reference memory image updated by a word-by-word command model, and
// directed plus randomized command scenarios.
// -----------------------------------------------------------------------------
module tb_mem_block_mover;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [9:0]  src_addr;
  logic [9:0]  dst_addr;
  logic [10:0] len;
  logic [15:0] fill_data;
  logic        busy;
  logic        done;
  logic [15:0] checksum;
  logic [9:0]  mem_addr;
  logic        mem_w_en;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] mem     [1024];
  logic [15:0] ref_mem [1024];

  logic        bd_we;
  logic [9:0]  bd_addr;
  logic [15:0] bd_data;

  mem_block_mover dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
    .fill_data (fill_data),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum),
    .mem_addr  (mem_addr),
    .mem_w_en  (mem_w_en),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: synchronous write, combinational read, plus a
  // backdoor write port used by the bench for preloading.
  always @(posedge clk) begin
    if (mem_w_en) mem[mem_addr] <= mem_wdata;
    if (bd_we)    mem[bd_addr]  <= bd_data;
  end
  assign mem_rdata = mem[mem_addr];

  task automatic poke(input int a, input logic [15:0] d);
    bd_we   = 1'b1;
    bd_addr = 10'(a);
    bd_data = d;
    @(negedge clk);
    bd_we   = 1'b0;
    ref_mem[a % 1024] = d;
  endtask

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  // Reference: forward word-by-word effect of one command on ref_mem.
  task automatic model_cmd(input logic m, input int s, input int d, input int ln,
                           input logic [15:0] f, output logic [15:0] cs, output int el);
    el = (ln > 1024) ? 1024 : ln;
    cs = 16'h0000;
    for (int k = 0; k < el; k++) begin
      logic [15:0] v;
      v = m ? f : ref_mem[(s + k) % 1024];
      ref_mem[(d + k) % 1024] = v;
      cs = cs + v;
    end
  endtask

  // Issue one command and observe it until done (bounded), then one idle cycle.
  task automatic run_cmd(input logic m, input int s, input int d, input int ln,
                         input logic [15:0] f, input bit poke_start,
                         output int busy_n, output int done_n, output int wr_n,
                         output bit tmo, output logic busy_after,
                         output logic w_en_after, output logic [9:0] addr_after);
    int cyc;
    mode = m; src_addr = 10'(s); dst_addr = 10'(d); len = 11'(ln); fill_data = f;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_n = 0; done_n = 0; wr_n = 0; tmo = 1'b0; cyc = 0;
    while (1) begin
      if (busy)     busy_n++;
      if (done)     done_n++;
      if (mem_w_en) wr_n++;
      if (done) break;
      if (cyc >= 5000) begin tmo = 1'b1; break; end
      if (poke_start && cyc == 1) begin
        start = 1'b1; mode = ~m; len = 11'd7;
        src_addr = ~src_addr; dst_addr = ~dst_addr; fill_data = ~f;
      end else begin
        start = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    busy_after = busy; w_en_after = mem_w_en; addr_after = mem_addr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %0b expected 0", done); end
    vectors++; if (checksum !== 16'h0) begin miscompares++; $display("FAIL reset_checksum: got 0x%04h expected 0x0000", checksum); end
    vectors++; if (mem_addr !== 10'h0) begin miscompares++; $display("FAIL reset_mem_addr: got 0x%03h expected 0x000", mem_addr); end
    vectors++; if (mem_w_en !== 1'b0) begin miscompares++; $display("FAIL reset_mem_w_en: got %0b expected 0", mem_w_en); end
    vectors++; if (mem_wdata !== 16'h0) begin miscompares++; $display("FAIL reset_mem_wdata: got 0x%04h expected 0x0000", mem_wdata); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill();
    int b, dn, w, el; bit tmo; logic ba, wa; logic [9:0] aa; logic [15:0] cs;
    model_cmd(1'b1, 'h010, 'h010, 4, 16'hA5A5, cs, el);
    run_cmd(1'b1, 'h010, 'h010, 4, 16'hA5A5, 1'b0, b, dn, w, tmo, ba, wa, aa);
    vectors++; if (tmo !== 1'b0) begin miscompares++; $display("FAIL fill_timeout: got %0b expected 0", tmo); end
    vectors++; if (b !== 5) begin miscompares++; $display("FAIL fill_busy_cycles: got %0d expected 5", b); end
    vectors++; if (dn !== 1) begin miscompares++; $display("FAIL fill_done_pulses: got %0d expected 1", dn); end
    vectors++; if (w !== 4) begin miscompares++; $display("FAIL fill_writes: got %0d expected 4", w); end
    vectors++; if (checksum !== 16'h9694) begin miscompares++; $display("FAIL fill_checksum: got 0x%04h expected 0x9694", checksum); end
    vectors++; if (mem[16'h013] !== 16'hA5A5) begin miscompares++; $display("FAIL fill_last_word: got 0x%04h expected 0xa5a5", mem[16'h013]); end
    vectors++; if (mem_diffs() !== 0) begin miscompares++; $display("FAIL fill_memory: got %0d bad words expected 0", mem_diffs()); end
    vectors++; if (ba !== 1'b0) begin miscompares++; $display("FAIL fill_busy_after: got %0b expected 0", ba); end
  endtask

  task automatic test_copy();
    int b, dn, w, el; bit tmo; logic ba, wa; logic [9:0] aa; logic [15:0] cs;
    poke(0, 16'd1); poke(1, 16'd2); poke(2, 16'd3);
    model_cmd(1'b0, 0, 'h100, 3, 16'h0, cs, el);
    run_cmd(1'b0, 0, 'h100, 3, 16'hDEAD, 1'b0, b, dn, w, tmo, ba, wa, aa);
    vectors++; if (tmo !== 1'b0) begin miscompares++; $display("FAIL copy_timeout: got %0b expected 0", tmo); end
    vectors++; if (b !== 7) begin miscompares++; $display("FAIL copy_busy_cycles: got %0d expected 7", b); end
    vectors++; if (w !== 3) begin miscompares++; $display("FAIL copy_writes: got %0d expected 3", w); end
    vectors++; if (checksum !== 16'h0006) begin miscompares++; $display("FAIL copy_checksum: got 0x%04h expected 0x0006", checksum); end
    vectors++; if (mem[16'h102] !== 16'd3) begin miscompares++; $display("FAIL copy_word2: got 0x%04h expected 0x0003", mem[16'h102]); end
    vectors++; if (mem_diffs() !== 0) begin miscompares++; $display("FAIL copy_memory: got %0d bad words expected 0", mem_diffs()); end
  endtask

  task automatic test_wrap();
    int b, dn, w, el; bit tmo; logic ba, wa; logic [9:0] aa; logic [15:0] cs, f;
    poke('h3FE, 16'd5); poke('h3FF, 16'd6); poke('h000, 16'd7); poke('h001, 16'd8);
    model_cmd(1'b0, 'h3FE, 'h1FF, 4, 16'h0, cs, el);
    run_cmd(1'b0, 'h3FE, 'h1FF, 4, 16'h0, 1'b0, b, dn, w, tmo, ba, wa, aa);
    vectors++; if (checksum !== 16'd26) begin miscompares++; $display("FAIL wrap_copy_checksum: got 0x%04h expected 0x001a", checksum); end
    vectors++; if (mem[16'h202] !== 16'd8) begin miscompares++; $display("FAIL wrap_copy_word3: got 0x%04h expected 0x0008", mem[16'h202]); end
    vectors++; if (mem_diffs() !== 0) begin miscompares++; $display("FAIL wrap_copy_memory: got %0d bad words expected 0", mem_diffs()); end
    f = 16'($urandom);
    model_cmd(1'b1, 0, 'h3FF, 2, f, cs, el);
    run_cmd(1'b1, 0, 'h3FF, 2, f, 1'b0, b, dn, w, tmo, ba, wa, aa);
    vectors++; if (b !== 3) begin miscompares++; $display("FAIL wrap_fill_busy_cycles: got %0d expected 3", b); end
    vectors++; if (mem[0] !== f) begin miscompares++; $display("FAIL wrap_fill_word0: got 0x%04h expected 0x%04h", mem[0], f); end
    vectors++; if (mem_diffs() !== 0) begin miscompares++; $display("FAIL wrap_fill_memory: got %0d bad words expected 0", mem_diffs()); end
    vectors++; if (aa !== 10'h000) begin miscompares++; $display("FAIL wrap_fill_idle_addr: got 0x%03h expected 0x000", aa); end
  endtask

  task automatic test_len_edges();
    int b, dn, w, el, d; bit tmo; logic ba, wa; logic [9:0] aa; logic [15:0] cs, f;
    run_cmd(1'b0, 'h055, 'h2AA, 0, 16'h0, 1'b0, b, dn, w, tmo, ba, wa, aa);
    vectors++; if (b !== 1) begin miscompares++; $display("FAIL len0_busy_cycles: got %0d expected 1", b); end
    vectors++; if (dn !== 1) begin miscompares++; $display("FAIL len0_done_pulses: got %0d expected 1", dn); end
    vectors++; if (w !== 0) begin miscompares++; $display("FAIL len0_writes: got %0d expected 0", w); end
    vectors++; if (checksum !== 16'h0) begin miscompares++; $display("FAIL len0_checksum: got 0x%04h expected 0x0000", checksum); end
    vectors++; if (mem_diffs() !== 0) begin miscompares++; $display("FAIL len0_memory: got %0d bad words expected 0", mem_diffs()); end
    d = $urandom_range(0, 1023); f = 16'($urandom);
    model_cmd(1'b1, 0, d, 2000, f, cs, el);
    run_cmd(1'b1, 0, d, 2000, f, 1'b0, b, dn, w, tmo, ba, wa, aa);
    vectors++; if (tmo !== 1'b0) begin miscompares++; $display("FAIL len2000_timeout: got %0b expected 0", tmo); end
    vectors++; if (b !== 1025) begin miscompares++; $display("FAIL len2000_busy_cycles: got %0d expected 1025", b); end
    vectors++; if (w !== 1024) begin miscompares++; $display("FAIL len2000_writes: got %0d expected 1024", w); end
    vectors++; if (checksum !== cs) begin miscompares++; $display("FAIL len2000_checksum: got 0x%04h expected 0x%04h", checksum, cs); end
    vectors++; if (mem_diffs() !== 0) begin miscompares++; $display("FAIL len2000_memory: got %0d bad words expected 0", mem_diffs()); end
  endtask

  task automatic test_overlap();
    int b, dn, w, el; bit tmo; logic ba, wa; logic [9:0] aa; logic [15:0] cs;
    poke('h020, 16'h1111);
    model_cmd(1'b0, 'h020, 'h021, 3, 16'h0, cs, el);
    run_cmd(1'b0, 'h020, 'h021, 3, 16'h0, 1'b0, b, dn, w, tmo, ba, wa, aa);
    for (int k = 'h21; k <= 'h23; k++) begin
      vectors++; if (mem[k] !== 16'h1111) begin miscompares++; $display("FAIL overlap_word_%03h: got 0x%04h expected 0x1111", k, mem[k]); end
    end
    vectors++; if (checksum !== 16'h3333) begin miscompares++; $display("FAIL overlap_checksum: got 0x%04h expected 0x3333", checksum); end
    vectors++; if (mem_diffs() !== 0) begin miscompares++; $display("FAIL overlap_memory: got %0d bad words expected 0", mem_diffs()); end
  endtask

  task automatic test_reset_abort();
    int b, dn, w, el, d, cyc, wr; bit tmo, seen_done; logic ba, wa; logic [9:0] aa;
    logic [15:0] cs, f;
    d = $urandom_range(0, 1023); f = 16'($urandom);
    mode = 1'b1; dst_addr = 10'(d); len = 11'd8; fill_data = f; start = 1'b1;
    @(negedge clk);
    start = 1'b0; wr = 0; cyc = 0; seen_done = 1'b0;
    while (1) begin
      if (done) seen_done = 1'b1;
      if (mem_w_en) wr++;
      if (wr >= 3 || cyc >= 100) break;
      cyc++;
      @(negedge clk);
    end
    vectors++; if (wr !== 3) begin miscompares++; $display("FAIL abort_reached_word2: got %0d writes expected 3", wr); end
    rst_n = 1'b0;
    @(negedge clk);
    if (done) seen_done = 1'b1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %0b expected 0", busy); end
    vectors++; if (mem_w_en !== 1'b0) begin miscompares++; $display("FAIL abort_mem_w_en: got %0b expected 0", mem_w_en); end
    vectors++; if (mem_addr !== 10'h0) begin miscompares++; $display("FAIL abort_mem_addr: got 0x%03h expected 0x000", mem_addr); end
    vectors++; if (mem_wdata !== 16'h0) begin miscompares++; $display("FAIL abort_mem_wdata: got 0x%04h expected 0x0000", mem_wdata); end
    vectors++; if (checksum !== 16'h0) begin miscompares++; $display("FAIL abort_checksum: got 0x%04h expected 0x0000", checksum); end
    @(negedge clk);
    if (done) seen_done = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    if (done) seen_done = 1'b1;
    vectors++; if (seen_done !== 1'b0) begin miscompares++; $display("FAIL abort_done_pulse: got %0b expected 0", seen_done); end
    ref_mem[d % 1024] = f;
    ref_mem[(d + 1) % 1024] = f;
    if (mem[(d + 2) % 1024] === f) ref_mem[(d + 2) % 1024] = f;
    vectors++; if (mem_diffs() !== 0) begin miscompares++; $display("FAIL abort_memory: got %0d bad words expected 0", mem_diffs()); end
    model_cmd(1'b0, d, (d + 500) % 1024, 5, 16'h0, cs, el);
    run_cmd(1'b0, d, (d + 500) % 1024, 5, 16'h0, 1'b0, b, dn, w, tmo, ba, wa, aa);
    vectors++; if (b !== 11) begin miscompares++; $display("FAIL abort_restart_busy: got %0d expected 11", b); end
    vectors++; if (checksum !== cs) begin miscompares++; $display("FAIL abort_restart_checksum: got 0x%04h expected 0x%04h", checksum, cs); end
    vectors++; if (mem_diffs() !== 0) begin miscompares++; $display("FAIL abort_restart_memory: got %0d bad words expected 0", mem_diffs()); end
  endtask

  task automatic test_back_to_back();
    int b, dn, w, el, s, d; bit tmo; logic ba, wa; logic [9:0] aa; logic [15:0] cs, f;
    s = $urandom_range(0, 1023); d = $urandom_range(0, 1023);
    model_cmd(1'b0, s, d, 6, 16'h0, cs, el);
    run_cmd(1'b0, s, d, 6, 16'h0, 1'b1, b, dn, w, tmo, ba, wa, aa);
    vectors++; if (b !== 13) begin miscompares++; $display("FAIL ignore_start_busy: got %0d expected 13", b); end
    vectors++; if (w !== 6) begin miscompares++; $display("FAIL ignore_start_writes: got %0d expected 6", w); end
    vectors++; if (ba !== 1'b0) begin miscompares++; $display("FAIL ignore_start_not_queued: got busy %0b expected 0", ba); end
    vectors++; if (mem_diffs() !== 0) begin miscompares++; $display("FAIL ignore_start_memory: got %0d bad words expected 0", mem_diffs()); end
    f = 16'($urandom);
    model_cmd(1'b1, 0, s, 3, f, cs, el);
    run_cmd(1'b1, 0, s, 3, f, 1'b0, b, dn, w, tmo, ba, wa, aa);
    vectors++; if (b !== 4) begin miscompares++; $display("FAIL b2b_busy: got %0d expected 4", b); end
    repeat (3) @(negedge clk);
    vectors++; if (checksum !== cs) begin miscompares++; $display("FAIL b2b_checksum_hold: got 0x%04h expected 0x%04h", checksum, cs); end
    vectors++; if (mem_diffs() !== 0) begin miscompares++; $display("FAIL b2b_memory: got %0d bad words expected 0", mem_diffs()); end
  endtask

  task automatic test_random();
    int b, dn, w, el, s, d, ln, r, eb; bit tmo; logic m, ba, wa; logic [9:0] aa;
    logic [15:0] cs, f;
    for (int it = 0; it < 24; it++) begin
      m = 1'($urandom_range(0, 1));
      s = $urandom_range(0, 1023); d = $urandom_range(0, 1023);
      f = 16'($urandom); r = $urandom_range(0, 9);
      ln = (r == 0) ? 0 : (r == 1) ? $urandom_range(1000, 2047) : $urandom_range(1, 40);
      model_cmd(m, s, d, ln, f, cs, el);
      eb = m ? el + 1 : 2 * el + 1;
      run_cmd(m, s, d, ln, f, 1'b0, b, dn, w, tmo, ba, wa, aa);
      vectors++; if (b !== eb) begin miscompares++; $display("FAIL rand%0d_busy: got %0d expected %0d", it, b, eb); end
      vectors++; if (dn !== 1) begin miscompares++; $display("FAIL rand%0d_done: got %0d expected 1", it, dn); end
      vectors++; if (w !== el) begin miscompares++; $display("FAIL rand%0d_writes: got %0d expected %0d", it, w, el); end
      vectors++; if (checksum !== cs) begin miscompares++; $display("FAIL rand%0d_checksum: got 0x%04h expected 0x%04h", it, checksum, cs); end
      vectors++; if (mem_diffs() !== 0) begin miscompares++; $display("FAIL rand%0d_memory: got %0d bad words expected 0", it, mem_diffs()); end
      vectors++; if ({ba, wa} !== 2'b00) begin miscompares++; $display("FAIL rand%0d_idle: got busy=%0b w_en=%0b expected 0 0", it, ba, wa); end
      if (el > 0) begin
        vectors++; if (aa !== 10'((d + el - 1) % 1024)) begin miscompares++; $display("FAIL rand%0d_idle_addr: got 0x%03h expected 0x%03h", it, aa, 10'((d + el - 1) % 1024)); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0; fill_data = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    test_reset();
    for (int i = 0; i < 1024; i++) poke(i, 16'($urandom));
    test_fill();
    test_copy();
    test_wrap();
    test_len_edges();
    test_overlap();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mem_block_mover
